// File: rtl/dcache_wbuf_axi_pkg.sv
// Shared constants and FSM encoding for the D-cache write-back buffer AXI master.
package dcache_wbuf_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2,
        StResp = 2'd3
    } wb_state_e;

endpackage

// File: rtl/dcache_wbuf_axi.sv
// Write-back buffer: holds one victim cache line and writes it out as a single
// AXI INCR burst of 32-bit beats. Optional macro DCACHE_WBUF_BRESP_CHECK_EN
// enables a sticky bus-error flag driven by non-OKAY write responses.
module dcache_wbuf_axi
    import dcache_wbuf_axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WORDS = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wbuf_we,
    input  logic                     wbuf_reset,
    input  logic [ADDR_WIDTH-1:0]    w_addr,
    input  logic [32*LINE_WORDS-1:0] w_line,
    input  logic                     w_req,
    output logic                     w_rdy,
    output logic                     wrt_finish,
    output logic [ADDR_WIDTH-1:0]    aw_addr,
    output logic [7:0]               aw_len,
    output logic [2:0]               aw_size,
    output logic [1:0]               aw_burst,
    output logic                     aw_valid,
    input  logic                     aw_ready,
    output logic [31:0]              w_data,
    output logic [3:0]               w_strb,
    output logic                     w_last,
    output logic                     w_valid,
    input  logic                     w_ready,
    input  logic [1:0]               b_resp,
    input  logic                     b_valid,
    output logic                     b_ready,
    output logic                     wbuf_err
);

    localparam int unsigned CntW = $clog2(LINE_WORDS);
    localparam int unsigned OffW = $clog2(4 * LINE_WORDS);
    localparam logic [CntW-1:0] LastBeat = CntW'(LINE_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] AddrMask =
        ~ADDR_WIDTH'((64'd1 << OffW) - 64'd1);

    wb_state_e               state_q, state_d;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [32*LINE_WORDS-1:0] line_q;
    logic [CntW-1:0]          cnt_q;
    logic [CntW+4:0]          bit_idx;
    logic                     capture;
    logic                     accept;
    logic                     resp_done;

    assign capture   = (state_q == StIdle) && wbuf_we;
    assign accept    = (state_q == StIdle) && w_req && !wbuf_we && !rst;
    assign resp_done = (state_q == StResp) && b_valid;
    assign bit_idx   = {cnt_q, 5'd0};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Line buffer: only loaded in IDLE, so it is frozen for the whole burst.
    always_ff @(posedge clk) begin
        if (capture) begin
            addr_q <= w_addr & AddrMask;
            line_q <= w_line;
        end
    end

    // Beat counter: cleared while in ADDR, saturates on the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == StAddr) begin
            cnt_q <= '0;
        end else if (state_q == StData && w_ready && cnt_q != LastBeat) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Sticky completion flag; setting wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst)                       wrt_finish <= 1'b0;
        else if (resp_done)            wrt_finish <= 1'b1;
        else if (wbuf_reset || accept) wrt_finish <= 1'b0;
    end

`ifdef DCACHE_WBUF_BRESP_CHECK_EN
    // Sticky bus error, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst)                                       wbuf_err <= 1'b0;
        else if (resp_done && b_resp != AXI_RESP_OKAY) wbuf_err <= 1'b1;
    end
`else
    logic unused_bresp;
    assign unused_bresp = ^b_resp;
    assign wbuf_err     = 1'b0;
`endif

    // Next-state and outputs; AXI outputs decode only from registered state.
    always_comb begin
        state_d  = state_q;
        w_rdy    = 1'b0;
        aw_addr  = '0;
        aw_len   = 8'd0;
        aw_size  = 3'd0;
        aw_burst = 2'd0;
        aw_valid = 1'b0;
        w_data   = 32'd0;
        w_strb   = 4'd0;
        w_last   = 1'b0;
        w_valid  = 1'b0;
        b_ready  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    w_rdy   = 1'b1;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                aw_valid = 1'b1;
                aw_addr  = addr_q;
                aw_len   = 8'(LINE_WORDS - 1);
                aw_size  = AXI_SIZE_4B;
                aw_burst = AXI_BURST_INCR;
                if (aw_ready) state_d = StData;
            end
            StData: begin
                w_valid = 1'b1;
                w_strb  = 4'hF;
                w_data  = line_q[bit_idx +: 32];
                w_last  = (cnt_q == LastBeat);
                if (w_ready && cnt_q == LastBeat) state_d = StResp;
            end
            StResp: begin
                b_ready = 1'b1;
                if (b_valid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_dcache_wbuf_axi.sv
// Self-checking bench for dcache_wbuf_axi: directed stimulus feeds expected AW
// and W beats into queues; a negedge monitor pops and compares on handshakes.
module tb_dcache_wbuf_axi;

    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          wbuf_we, wbuf_reset, w_req;
    logic [31:0]   w_addr;
    logic [32*LW-1:0] w_line;
    logic          w_rdy, wrt_finish;
    logic [31:0]   aw_addr;
    logic [7:0]    aw_len;
    logic [2:0]    aw_size;
    logic [1:0]    aw_burst;
    logic          aw_valid, aw_ready;
    logic [31:0]   w_data;
    logic [3:0]    w_strb;
    logic          w_last, w_valid, w_ready;
    logic [1:0]    b_resp;
    logic          b_valid, b_ready, wbuf_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_aw_q[$];
    logic [32:0] exp_w_q[$];
    logic [32:0] exp_w;
    logic [31:0] exp_a;
    logic        stall_prev = 1'b0;
    logic [31:0] stall_data = 32'd0;
    logic        toggle_en  = 1'b0;
    logic        exp_err;

    always #5 clk = ~clk;

    dcache_wbuf_axi #(.ADDR_WIDTH(32), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst), .wbuf_we(wbuf_we), .wbuf_reset(wbuf_reset),
        .w_addr(w_addr), .w_line(w_line), .w_req(w_req), .w_rdy(w_rdy),
        .wrt_finish(wrt_finish), .aw_addr(aw_addr), .aw_len(aw_len),
        .aw_size(aw_size), .aw_burst(aw_burst), .aw_valid(aw_valid),
        .aw_ready(aw_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .w_valid(w_valid), .w_ready(w_ready), .b_resp(b_resp), .b_valid(b_valid),
        .b_ready(b_ready), .wbuf_err(wbuf_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every AW/W handshake against the scoreboard queues.
    always @(negedge clk) begin
        if (stall_prev) begin
            check("stall_valid", 64'(w_valid), 64'd1);
            check("stall_data", 64'(w_data), 64'(stall_data));
        end
        if (aw_valid && aw_ready) begin
            if (exp_aw_q.size() == 0) begin
                check("aw_unexpected", 64'd1, 64'd0);
            end else begin
                exp_a = exp_aw_q.pop_front();
                check("aw_addr", 64'(aw_addr), 64'(exp_a));
                check("aw_len", 64'(aw_len), 64'd15);
                check("aw_size", 64'(aw_size), 64'd2);
                check("aw_burst", 64'(aw_burst), 64'd1);
            end
        end
        if (w_valid && w_ready) begin
            if (exp_w_q.size() == 0) begin
                check("w_unexpected", 64'd1, 64'd0);
            end else begin
                exp_w = exp_w_q.pop_front();
                check("w_data", 64'(w_data), 64'(exp_w[31:0]));
                check("w_last", 64'(w_last), 64'(exp_w[32]));
                check("w_strb", 64'(w_strb), 64'hF);
            end
        end
        stall_prev = w_valid && !w_ready && !rst;
        stall_data = w_data;
    end

    // Slave back-pressure: toggles w_ready every cycle when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) w_ready = ~w_ready;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [31:0] addr, input logic [31:0] base);
        w_addr = addr;
        for (int i = 0; i < LW; i++) w_line[i*32 +: 32] = base + 32'(i);
        wbuf_we = 1'b1;
        tick();
        wbuf_we = 1'b0;
    endtask

    task automatic push_burst(input logic [31:0] addr, input logic [31:0] base, input int nbeats);
        exp_aw_q.push_back(addr);
        for (int i = 0; i < nbeats; i++) exp_w_q.push_back({(i == LW - 1), base + 32'(i)});
    endtask

    // Issues w_req for one cycle; leaves the bench in cycle 1 (ADDR).
    task automatic start(input string name);
        w_req = 1'b1;
        @(negedge clk);
        check(name, 64'(w_rdy), 64'd1);
        tick();
        w_req = 1'b0;
    endtask

    task automatic wait_finish(input string name);
        for (int k = 0; k < 200 && !wrt_finish; k++) tick();
        @(negedge clk);
        check(name, 64'(wrt_finish), 64'd1);
        check({name, "_aw_drain"}, 64'(exp_aw_q.size()), 64'd0);
        check({name, "_w_drain"}, 64'(exp_w_q.size()), 64'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef DCACHE_WBUF_BRESP_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        rst = 1'b1; wbuf_we = 1'b0; wbuf_reset = 1'b0; w_req = 1'b0;
        w_addr = '0; w_line = '0; aw_ready = 1'b1; w_ready = 1'b1;
        b_resp = 2'b00; b_valid = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rst_aw_valid", 64'(aw_valid), 64'd0);
        check("rst_w_valid", 64'(w_valid), 64'd0);
        check("rst_w_last", 64'(w_last), 64'd0);
        check("rst_b_ready", 64'(b_ready), 64'd0);
        check("rst_finish", 64'(wrt_finish), 64'd0);
        check("rst_err", 64'(wbuf_err), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Basic burst with exact latency; wbuf_reset in the setting cycle loses.
        capture(32'h8000_0040, 32'h100);
        push_burst(32'h8000_0040, 32'h100, LW);
        start("t1_w_rdy");
        @(negedge clk);
        check("t1_w_rdy_pulse", 64'(w_rdy), 64'd0);
        for (int k = 2; k <= 18; k++) tick();
        @(negedge clk);
        check("t1_finish_early", 64'(wrt_finish), 64'd0);
        check("t1_b_ready", 64'(b_ready), 64'd1);
        wbuf_reset = 1'b1;
        tick();
        wbuf_reset = 1'b0;
        @(negedge clk);
        check("t1_finish_c19", 64'(wrt_finish), 64'd1);
        check("t1_aw_drain", 64'(exp_aw_q.size()), 64'd0);
        check("t1_w_drain", 64'(exp_w_q.size()), 64'd0);
        tick();

        // Clear, then stalled burst with unaligned address and a late capture attempt.
        wbuf_reset = 1'b1;
        tick();
        wbuf_reset = 1'b0;
        @(negedge clk);
        check("t2_finish_clr", 64'(wrt_finish), 64'd0);
        tick();
        capture(32'h1234_5678, 32'h200);
        push_burst(32'h1234_5640, 32'h200, LW);
        toggle_en = 1'b1;
        start("t2_w_rdy");
        tick();
        wbuf_we = 1'b1;
        w_req   = 1'b1;
        w_addr  = 32'hFFFF_0000;
        for (int i = 0; i < LW; i++) w_line[i*32 +: 32] = 32'hDEAD_0000 + 32'(i);
        @(negedge clk);
        check("t2_w_rdy_busy", 64'(w_rdy), 64'd0);
        tick();
        wbuf_we = 1'b0;
        w_req   = 1'b0;
        wait_finish("t2_finish");
        toggle_en = 1'b0;
        w_ready   = 1'b1;
        tick();

        // Reset at beat 7, then restart from beat 0.
        capture(32'h4000_0000, 32'h300);
        push_burst(32'h4000_0000, 32'h300, 8);
        start("t3_w_rdy");
        for (int k = 0; k < 8; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t3_aw_valid", 64'(aw_valid), 64'd0);
        check("t3_w_valid", 64'(w_valid), 64'd0);
        check("t3_w_last", 64'(w_last), 64'd0);
        check("t3_b_ready", 64'(b_ready), 64'd0);
        check("t3_finish", 64'(wrt_finish), 64'd0);
        check("t3_w_drain", 64'(exp_w_q.size()), 64'd0);
        tick();
        push_burst(32'h4000_0000, 32'h300, LW);
        start("t3_restart_w_rdy");
        wait_finish("t3_finish_restart");

        // Error response.
        b_resp = 2'b10;
        capture(32'h0000_1000, 32'h400);
        push_burst(32'h0000_1000, 32'h400, LW);
        start("t4_w_rdy");
        wait_finish("t4_finish");
        b_resp = 2'b00;
        @(negedge clk);
        check("t4_err", 64'(wbuf_err), 64'(exp_err));
        tick();
        wbuf_reset = 1'b1;
        tick();
        wbuf_reset = 1'b0;
        @(negedge clk);
        check("t4_finish_clr", 64'(wrt_finish), 64'd0);
        check("t4_err_sticky", 64'(wbuf_err), 64'(exp_err));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t4_err_rst", 64'(wbuf_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
